// File: rtl/multi_hot_encoder.sv
// multi_hot_encoder: latches a multi-hot request vector and emits the binary
// index of every set bit, one index per output beat, flagging the final beat.
// An accepted all-zero vector is discarded and reported with drop_pulse.
//
// Build option: define MULTI_HOT_ENCODER_MSB_FIRST_EN to emit indices highest
// first (descending). The default build emits lowest first (ascending).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. out_valid, once raised, stays high with binary_out/out_last
// stable until out_ready takes the beat; in_ready never depends on in_valid.
module multi_hot_encoder #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  encoder_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] binary_out,
  output logic             out_last,
  output logic             drop_pulse
);

  // Reject parameter combinations the index width cannot represent.
  if (IN_W < 2 || IN_W > 256) begin : g_bad_in_w
    $error("multi_hot_encoder: IN_W must be within 2..256");
  end
  if (OUT_W != $clog2(IN_W)) begin : g_bad_out_w
    $error("multi_hot_encoder: OUT_W must equal ceil(log2(IN_W))");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IN_W-1:0]   r_pending;
  logic [IN_W-1:0]   w_pending_nxt;
  logic              r_drop;
  logic              w_accept;
  logic              w_take;
  logic [OUT_W-1:0]  w_idx;
  logic [IN_W-1:0]   w_sel_mask;
  logic              w_single;

  assign in_ready   = rst_n & (r_state == ST_IDLE) & enable;
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = (r_state == ST_EMIT);
  assign w_take     = out_valid & out_ready;
  assign binary_out = w_idx;
  assign out_last   = w_single;
  assign drop_pulse = r_drop;

  // Pick the next index from the pending bits; pending is zero outside EMIT,
  // so the index reads as zero there.
  always_comb begin
    w_idx = '0;
`ifdef MULTI_HOT_ENCODER_MSB_FIRST_EN
    for (int i = 0; i < IN_W; i++) begin
      if (r_pending[i]) w_idx = OUT_W'(i);
    end
`else
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = OUT_W'(i);
    end
`endif
  end

  assign w_sel_mask = IN_W'(1) << w_idx;
  // Exactly one pending bit left means the current beat is the final one.
  assign w_single   = (r_pending != '0) &&
                      ((r_pending & (r_pending - IN_W'(1))) == '0);

  // Next-state and next-pending selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (encoder_in != '0)) begin
          w_pending_nxt = encoder_in;
          w_state_nxt   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_take) begin
          w_pending_nxt = r_pending & ~w_sel_mask;
          if (w_single) w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  // State and pending register; reset discards any in-flight vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // One-cycle pulse after an all-zero vector is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_accept && (encoder_in == '0);
    end
  end

endmodule

// File: tb/tb_multi_hot_encoder.sv
// Testbench for multi_hot_encoder: randomized vectors checked against a
// list-of-set-bit-indices reference model.
module tb_multi_hot_encoder;

  localparam int IN_W  = 16;
  localparam int OUT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  encoder_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] binary_out;
  logic             out_last;
  logic             drop_pulse;

  int checks;
  int failures;

  multi_hot_encoder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .encoder_in (encoder_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .binary_out (binary_out),
    .out_last   (out_last),
    .drop_pulse (drop_pulse)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: indices of set bits in emission order.
  task automatic build_expected(input logic [IN_W-1:0] vec,
                                output logic [OUT_W-1:0] q[$]);
    q = {};
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
`ifdef MULTI_HOT_ENCODER_MSB_FIRST_EN
        q.push_front(OUT_W'(i));
`else
        q.push_back(OUT_W'(i));
`endif
      end
    end
  endtask

  // Offer a vector until accepted; returns at the negedge after acceptance.
  task automatic accept_vector(input logic [IN_W-1:0] vec, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      enable = 1'b1; in_valid = 1'b1; encoder_in = vec;
      #1;
      if (in_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    encoder_in = IN_W'($urandom);
  endtask

  // Send one vector and drain its beats. mode: 0 ready always, 1 toggle, 2 random.
  task automatic run_vector(input logic [IN_W-1:0] vec, input int mode, input bit en_noise);
    logic [OUT_W-1:0] exp_q[$];
    bit ok;
    bit rdy;
    int budget;
    build_expected(vec, exp_q);
    accept_vector(vec, ok);
    if (!ok) return;
    #1;
    if (vec == '0) begin
      checks++;
      if (drop_pulse !== 1'b1) begin
        failures++; $display("FAIL drop_high: drop_pulse=%0b required 1", drop_pulse);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL drop_no_beat: out_valid=%0b required 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL drop_in_ready: in_ready=%0b required 1", in_ready);
      end
      @(negedge clk); #1;
      checks++;
      if (drop_pulse !== 1'b0) begin
        failures++; $display("FAIL drop_one_cycle: drop_pulse=%0b required 0", drop_pulse);
      end
      return;
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL out_valid: got %0b required 1 (beats left %0d)", out_valid, exp_q.size());
      end
      checks++;
      if (binary_out !== exp_q[0]) begin
        failures++; $display("FAIL binary_out: got %0d required %0d", binary_out, exp_q[0]);
      end
      checks++;
      if (out_last !== (exp_q.size() == 1)) begin
        failures++; $display("FAIL out_last: got %0b required %0b", out_last, exp_q.size() == 1);
      end
      checks++;
      if (drop_pulse !== 1'b0) begin
        failures++; $display("FAIL drop_during_beat: drop_pulse=%0b required 0", drop_pulse);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = budget[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (en_noise) enable = 1'($urandom_range(0, 1));
      if (rdy && out_valid === 1'b1) void'(exp_q.pop_front());
      budget++;
      @(negedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL drain_timeout: beats left %0d required 0", exp_q.size());
    end
    out_ready = 1'b0;
    enable = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL extra_beat: out_valid=%0b required 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_last: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; encoder_in = '0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || drop_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_flags: valid=%0b last=%0b drop=%0b required 0 0 0", out_valid, out_last, drop_pulse);
    end
    checks++;
    if (binary_out !== '0) begin
      failures++; $display("FAIL reset_binary_out: got %0d required 0", binary_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_vector(16'h0001, 0, 1'b0);
    run_vector(16'h1111, 0, 1'b0);
    run_vector(16'h0110, 1, 1'b0);
    run_vector(16'hFFFF, 0, 1'b0);
  endtask

  task automatic test_enable();
    @(negedge clk);
    enable = 1'b0; in_valid = 1'b1; encoder_in = 16'h0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL enable_block: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
      end
      @(negedge clk);
    end
    run_vector(16'h0010, 0, 1'b0);
  endtask

  task automatic test_drop();
    run_vector(16'h0000, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    accept_vector(16'hFFFF, ok);
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++;
`ifdef MULTI_HOT_ENCODER_MSB_FIRST_EN
      if (binary_out !== OUT_W'(15 - b)) begin
        failures++; $display("FAIL mid_beat: got %0d required %0d", binary_out, 15 - b);
      end
`else
      if (binary_out !== OUT_W'(b)) begin
        failures++; $display("FAIL mid_beat: got %0d required %0d", binary_out, b);
      end
`endif
      @(negedge clk);
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 || binary_out !== '0) begin
      failures++; $display("FAIL mid_reset: valid=%0b ready=%0b last=%0b idx=%0d required 0 0 0 0", out_valid, in_ready, out_last, binary_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vector(16'h8000, 0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    logic [IN_W-1:0] vec;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0:       vec = '0;
        1:       vec = IN_W'(1) << $urandom_range(0, IN_W - 1);
        2:       vec = '1;
        default: vec = IN_W'($urandom);
      endcase
      run_vector(vec, 2, 1'b1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_enable();
    test_drop();
    test_reset_mid();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_hot_encoder.md
Name: multi_hot_encoder

Overview:
- Parametrised successor to the team's 16-to-4 combinational encoder with enable.
- Accepts a multi-hot request vector over a valid/ready handshake and latches it.
- Emits the binary index of every set bit, one index per beat, over a second valid/ready handshake. Marks the final beat.
- Sits between request collectors (interrupt/request lines) and downstream index consumers that need every asserted line serviced, not just one.

Parameters:
- IN_W, 16, width of the request vector; legal range 2..256.
- OUT_W, 4, width of the emitted index; must equal ceil(log2(IN_W)); elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  gates acceptance of new vectors only
- in_valid  input  1  encoder_in is valid
- in_ready  output  1  block can accept a vector
- encoder_in  input  IN_W  multi-hot request vector
- out_valid  output  1  binary_out is valid
- out_ready  input  1  consumer takes the current beat
- binary_out  output  OUT_W  index of the current selected set bit
- out_last  output  1  current beat is the final set bit of the vector
- drop_pulse  output  1  one-cycle pulse: an all-zero vector was accepted and discarded

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, pending=0, out_valid=0, binary_out=0, out_last=0, drop_pulse=0.
  - in_ready=0 while rst_n is low.
- State IDLE:
  - in_ready = enable.
  - On rising edge with in_valid & in_ready: if encoder_in != 0, pending <= encoder_in and go to EMIT.
  - If encoder_in == 0: stay in IDLE and assert drop_pulse in the following cycle for exactly one cycle.
- State EMIT:
  - in_ready=0 and out_valid=1.
  - binary_out = index of the lowest set bit of pending (LSB-first priority).
  - out_last=1 when pending has exactly one bit set.
  - Outputs derive only from registered state; no combinational path from encoder_in or in_valid to any output.
- Beat handshake:
  - On a rising edge with out_valid & out_ready, clear the selected bit in pending.
  - If out_last was 1, go to IDLE; otherwise stay in EMIT with the next set bit.
- Stall: with out_ready=0, binary_out, out_last and pending hold stable; out_valid never drops until the beat is taken.
- Latency:
  - Accept at edge N -> first beat valid in cycle N+1.
  - A vector with K set bits needs K beats minimum.
  - Last beat taken at edge M -> in_ready high in cycle M+1 (if enable=1) -> next accept no earlier than edge M+1.
  - One bubble cycle between vectors.
- enable:
  - Deasserting enable in IDLE blocks acceptance.
  - Deasserting enable in EMIT has no effect; the in-flight vector drains fully.
- Full vector: all IN_W bits set -> IN_W beats, indices 0..IN_W-1 ascending, out_last only on index IN_W-1.
- Single bit: exactly one beat, with out_last=1.
- Reset mid-EMIT: pending is discarded immediately; outputs go to reset values; no further beats.
- drop_pulse is independent of out_* and never coincides with out_valid for the same vector.

Optional Feature:
- MULTI_HOT_ENCODER_MSB_FIRST_EN
  - Defined: selection picks the highest set bit of pending first, so indices emit in descending order. out_last is asserted on the lowest set bit.
  - Undefined (default): LSB-first ascending order as above.
  - Handshake, latency and drop behaviour are identical in both builds.

Test Plan:
- Reset then enable=1, in_valid=1, encoder_in=16'h0001 -> one beat, binary_out=0, out_last=1; in_ready back high 1 cycle after the beat.
- encoder_in=16'h1111, out_ready=1 constantly -> beats 0,4,8,12 in consecutive cycles, out_last only on 12. With MSB_FIRST_EN: 12,8,4,0, out_last on 0.
- encoder_in=16'h0110, out_ready toggled 0/1 each cycle -> binary_out holds 4 through stall cycles, then 8 with out_last; no beat lost or duplicated.
- enable=0 with in_valid=1 and encoder_in=16'h0010 -> in_ready=0, no beats. Raise enable -> accepted, single beat binary_out=4.
- encoder_in=16'h0000 accepted -> drop_pulse high exactly one cycle, out_valid stays 0, in_ready high the next cycle.
- encoder_in=16'hFFFF, assert rst_n=0 after 3 beats -> out_valid=0 immediately. After release, a new 16'h8000 yields a single beat binary_out=15 (no stale indices).
